// File: rtl/mm_pkg.sv
// Shared definitions for the RSA datapath around the Montgomery multiplier.
//   state_t : top-level states of the modular-exponentiation controller
//   phase_t : sub-phases of one multiplier operation (ARM / ISSUE / WAIT)
//   MM_N    : default operand / modulus width
package mm_pkg;

    localparam int MM_N = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TO_MONT,
        ST_SQUARE,
        ST_MULT,
        ST_FROM_MONT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        PH_ARM,
        PH_ISSUE,
        PH_WAIT
    } phase_t;

endpackage

// File: rtl/modexp_ctrl.sv
// Modular-exponentiation controller: result = in_x^in_e mod in_m using
// left-to-right square-and-multiply in the Montgomery domain. It acts as the
// initiator of an external Montgomery multiplier and runs one operation at a time.
//
// Ports
//   clk, resetn          clock; synchronous active-low reset
//   start                one-cycle request, accepted only in IDLE or DONE
//   in_x/in_e/in_m       base, exponent and odd modulus (registered on start)
//   in_r, in_r2          R mod M and R^2 mod M, with R = 2^N
//   result, done         final value; done is a level held until the next start
//   busy                 high from the accepted start until done
//   mm_resetn, mm_start  multiplier reset and one-cycle start
//   mm_a, mm_b, mm_m     multiplier operands
//   mm_result, mm_done   multiplier output and its held done level
module modexp_ctrl
    import mm_pkg::*;
#(
    parameter int N       = MM_N,
    parameter int E_WIDTH = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [N-1:0]       in_x,
    input  logic [E_WIDTH-1:0] in_e,
    input  logic [N-1:0]       in_m,
    input  logic [N-1:0]       in_r,
    input  logic [N-1:0]       in_r2,
    output logic [N-1:0]       result,
    output logic               done,
    output logic               busy,
    output logic               mm_resetn,
    output logic               mm_start,
    output logic [N-1:0]       mm_a,
    output logic [N-1:0]       mm_b,
    output logic [N-1:0]       mm_m,
    input  logic [N-1:0]       mm_result,
    input  logic               mm_done
);

    localparam int            CW      = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam logic [CW-1:0] IDX_TOP = CW'(E_WIDTH - 1);

    state_t state, state_n;
    phase_t phase, phase_n;

    logic [N-1:0]       x_q, m_q, r2_q, xt_q, a_q;
    logic [E_WIDTH-1:0] e_q;
    logic [CW-1:0]      idx_q;

    logic active;
    logic accept;
    logic capture;

    assign active  = (state == ST_TO_MONT) || (state == ST_SQUARE) ||
                     (state == ST_MULT)    || (state == ST_FROM_MONT);
    assign accept  = start && ((state == ST_IDLE) || (state == ST_DONE));
    // mm_done is only trusted in WAIT: the multiplier was re-armed before ISSUE,
    // so any level seen earlier belongs to the previous operation.
    assign capture = active && (phase == PH_WAIT) && mm_done;

    // State register.
    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_IDLE;
            phase <= PH_ARM;
        end else begin
            state <= state_n;
            phase <= phase_n;
        end
    end

    // Next-state logic.
    // NOTE: defaults are assigned first so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        phase_n = phase;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_n = ST_TO_MONT;
                    phase_n = PH_ARM;
                end
            end
            default: begin
                unique case (phase)
                    PH_ARM:   phase_n = PH_ISSUE;
                    PH_ISSUE: phase_n = PH_WAIT;
                    default: begin
                        if (mm_done) begin
                            phase_n = PH_ARM;
                            unique case (state)
                                ST_TO_MONT: state_n = ST_SQUARE;
                                ST_SQUARE: begin
                                    if (e_q[idx_q])          state_n = ST_MULT;
                                    else if (idx_q == '0)    state_n = ST_FROM_MONT;
                                    else                     state_n = ST_SQUARE;
                                end
                                ST_MULT:   state_n = (idx_q == '0) ? ST_FROM_MONT : ST_SQUARE;
                                default:   state_n = ST_DONE;
                            endcase
                        end
                    end
                endcase
            end
        endcase
    end

    // Outputs decoded from state and phase; operands stay fixed for the whole
    // operation because A/XT only change on the capture edge that leaves it.
    always_comb begin
        mm_resetn = active && (phase != PH_ARM);
        mm_start  = active && (phase == PH_ISSUE);
        mm_m      = m_q;
        done      = (state == ST_DONE);
        busy      = active;
        mm_a      = '0;
        mm_b      = '0;
        unique case (state)
            ST_TO_MONT:   begin mm_a = x_q; mm_b = r2_q;  end
            ST_SQUARE:    begin mm_a = a_q; mm_b = a_q;   end
            ST_MULT:      begin mm_a = a_q; mm_b = xt_q;  end
            ST_FROM_MONT: begin mm_a = a_q; mm_b = N'(1); end
            default:      ;
        endcase
    end

    // Operand registers, accumulator and bit counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q    <= '0;
            e_q    <= '0;
            m_q    <= '0;
            r2_q   <= '0;
            xt_q   <= '0;
            a_q    <= '0;
            idx_q  <= '0;
            result <= '0;
        end else begin
            if (accept) begin
                x_q   <= in_x;
                e_q   <= in_e;
                m_q   <= in_m;
                r2_q  <= in_r2;
                a_q   <= in_r;     // A starts as 1 in the Montgomery domain
                idx_q <= IDX_TOP;
            end
            if (capture) begin
                unique case (state)
                    ST_TO_MONT:        xt_q   <= mm_result;
                    ST_SQUARE, ST_MULT: a_q   <= mm_result;
                    default:           result <= mm_result;
                endcase
                // A bit is finished after its square when the bit is 0, or
                // after its multiply when it is 1.
                if (((state == ST_SQUARE && !e_q[idx_q]) || state == ST_MULT) && idx_q != '0)
                    idx_q <= idx_q - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl with a behavioural Montgomery multiplier
// of configurable latency. Expected results come from plain repeated modular
// multiplication in the normal domain; a monitor pops them on each done edge.
module tb_modexp_ctrl;

    localparam int N  = 8;
    localparam int EW = 4;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          start  = 1'b0;
    logic [N-1:0]  in_x   = '0;
    logic [EW-1:0] in_e   = '0;
    logic [N-1:0]  in_m   = '0;
    logic [N-1:0]  in_r   = '0;
    logic [N-1:0]  in_r2  = '0;
    logic [N-1:0]  result;
    logic          done, busy, mm_resetn, mm_start;
    logic [N-1:0]  mm_a, mm_b, mm_m;
    logic [N-1:0]  mm_result = '0;
    logic          mm_done   = 1'b0;

    always #5 clk = ~clk;

    modexp_ctrl #(.N(N), .E_WIDTH(EW)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .in_x(in_x), .in_e(in_e), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .result(result), .done(done), .busy(busy),
        .mm_resetn(mm_resetn), .mm_start(mm_start),
        .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m),
        .mm_result(mm_result), .mm_done(mm_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural Montgomery multiplier ----------------
    int          lat    = 3;
    bit          sticky = 1'b0;   // keep mm_done high through reset (stale level)
    int          cnt    = 0;
    logic [N-1:0] pend  = '0;

    function automatic int mont(input int a, input int b, input int m);
        int rinv = 0;
        if (m <= 1) return 0;
        for (int i = 1; i < m; i++)
            if (((1 << N) * i) % m == 1) rinv = i;
        return ((a * b) % m) * rinv % m;
    endfunction

    always @(posedge clk) begin
        if (!mm_resetn) begin
            if (!sticky) mm_done <= 1'b0;
            cnt <= 0;
        end else if (mm_start) begin
            mm_done <= 1'b0;
            cnt     <= lat;
            pend    <= N'(mont(int'(mm_a), int'(mm_b), int'(mm_m)));
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                mm_done   <= 1'b1;
                mm_result <= pend;
            end
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct { int res; int ops; } exp_t;
    exp_t sb[$];
    int   run_m = 0;

    function automatic int ref_pow(input int x, input int e, input int m);
        int acc = 1 % m;
        for (int i = 0; i < e; i++) acc = (acc * x) % m;
        return acc;
    endfunction

    // ---------------- monitor ----------------
    int          starts_in_run = 0;
    logic        prev_done = 1'b0, prev_busy = 1'b0, prev_mmr = 1'b0;
    logic [N-1:0] prev_a = '0, prev_b = '0;
    exp_t        item;

    always @(negedge clk) begin
        if (busy && !prev_busy) starts_in_run = 0;
        if (mm_start) begin
            starts_in_run++;
            check("arm_before_issue", prev_mmr, 1'b0);
            check("operands_stable", {prev_a, prev_b}, {mm_a, mm_b});
            check("mm_m_is_modulus", mm_m, run_m);
        end
        if (done && !prev_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1'b1, 1'b0);
            end else begin
                item = sb.pop_front();
                check("result", result, item.res);
                check("op_count", starts_in_run, item.ops);
            end
        end
        prev_done = done;
        prev_busy = busy;
        prev_mmr  = mm_resetn;
        prev_a    = mm_a;
        prev_b    = mm_b;
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic set_inputs(input int x, input int e, input int m);
        int r = (1 << N) % m;
        in_x  = N'(x);
        in_e  = EW'(e);
        in_m  = N'(m);
        in_r  = N'(r);
        in_r2 = N'((r * r) % m);
    endtask

    task automatic launch(input int x, input int e, input int m);
        set_inputs(x, e, m);
        run_m = m;
        sb.push_back('{res: ref_pow(x, e, m), ops: EW + $countones(e) + 2});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("done_clear_after_start", done, 1'b0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_within_budget", done, 1'b1);
        check("busy_low_at_done", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, result, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mm_resetn"}, mm_resetn, 0);
        check({tag, "_mm_start"}, mm_start, 0);
        check({tag, "_mm_a"}, mm_a, 0);
        check({tag, "_mm_b"}, mm_b, 0);
        check({tag, "_mm_m"}, mm_m, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the M=13 setup.
        launch(2, 4'b0101, 13); wait_done();
        launch(2, 0, 13);       wait_done();
        launch(2, 4'b1111, 13); wait_done();
        for (int i = 0; i < 20; i++) begin
            check("held_result", result, 8);
            check("held_done", done, 1'b1);
            @(posedge clk); #1;
        end

        // Fast and slow multiplier with a stale mm_done level between operations.
        sticky = 1'b1;
        lat = 1;  launch(2, 4'b0101, 13); wait_done();
        lat = 50; launch(2, 4'b0101, 13); wait_done();
        sticky = 1'b0;
        lat = 3;

        // start while busy and input changes mid-run are ignored.
        launch(2, 4'b0101, 13);
        repeat (5) @(posedge clk);
        #1;
        set_inputs(3, 4'b1111, 11);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        set_inputs(7, 4'b0110, 9);
        wait_done();

        // Reset during the third multiplier operation.
        launch(2, 4'b0101, 13);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (starts_in_run < 3 && n < 2000);
        check("reached_third_op", starts_in_run, 3);
        resetn = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrun_reset");
        sb.delete();
        resetn = 1'b1;
        @(posedge clk); #1;
        launch(2, 4'b0101, 13); wait_done();

        // Randomised runs against the reference model.
        for (int t = 0; t < 20; t++) begin
            int m = 2 * $urandom_range(1, 127) + 1;
            lat = $urandom_range(1, 6);
            launch($urandom_range(0, m - 1), $urandom_range(0, 15), m);
            wait_done();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Modular-exponentiation controller that drives the Montgomery multiplier as its initiator. It computes result = in_x^in_e mod in_m by left-to-right square-and-multiply in the Montgomery domain. It issues one multiplier operation at a time over the multiplier's start/done interface and re-arms the multiplier between operations. It sits above the multiplier in the RSA datapath; the multiplier is instantiated beside it at the top level, not inside it.

## Interface
- N, 1024, operand/modulus width (multiplier width).
- E_WIDTH, 1024, exponent width; all E_WIDTH bits are scanned MSB first.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- in_x  in  N  base, normal domain, < in_m.
- in_e  in  E_WIDTH  exponent.
- in_m  in  N  odd modulus.
- in_r  in  N  R mod M, with R = 2^N.
- in_r2  in  N  R^2 mod M.
- result  out  N  x^e mod M; valid while done=1.
- done  out  1  level; high from completion until the next accepted start.
- busy  out  1  high from the accepted start until done.
- mm_resetn  out  1  drives the multiplier resetn.
- mm_start  out  1  one-cycle multiplier start.
- mm_a, mm_b, mm_m  out  N  multiplier operands.
- mm_result  in  N  multiplier output.
- mm_done  in  1  multiplier done (level, held until the multiplier is reset).

## Operation
- On an accepted start, register in_x, in_e, in_m, in_r and in_r2 internally. Later changes on the inputs have no effect.
- Operation sequence:
  - XT = MM(x, R2).
  - A = R mod M.
  - For i = E_WIDTH-1 down to 0: A = MM(A, A); if e[i], A = MM(A, XT).
  - result = MM(A, 1).
- Operation count = E_WIDTH + popcount(e) + 2.
- mm_m = registered M throughout a run.
- Top FSM states: IDLE, TO_MONT, SQUARE, MULT, FROM_MONT, DONE.
- Each multiplier operation uses three sub-phases:
  - ARM: mm_resetn=0 for one cycle.
  - ISSUE: mm_resetn=1, mm_start=1 for one cycle.
  - WAIT: hold operands until mm_done=1.
- Result capture: on the first cycle in WAIT with mm_done=1, latch mm_result into XT (TO_MONT), A (SQUARE/MULT) or result (FROM_MONT), then advance.
- Transitions:
  - TO_MONT → SQUARE.
  - SQUARE → MULT if e[i]=1; otherwise decrement i, then go to SQUARE, or to FROM_MONT when i was 0.
  - MULT → decrement i, same rule as SQUARE.
  - FROM_MONT → DONE.
- Bit counter is $clog2(E_WIDTH) bits wide and is loaded with E_WIDTH-1 on start.
- e = 0: the result is 1 mod M.

## Timing
- Reset values:
  - result=0, done=0, busy=0, mm_start=0.
  - mm_resetn=0: the multiplier is held in reset.
  - mm_a=mm_b=mm_m=0.
  - State IDLE.
- In IDLE, mm_resetn=0.
- Accepted start at edge k: busy=1 from k+1, and ARM of TO_MONT occurs in cycle k+1.
- Per-operation overhead = 2 cycles plus 1 capture cycle beyond the multiplier's own latency.
- mm_a and mm_b are stable from ARM through the capture cycle.
- done rises on the edge after the FROM_MONT capture, together with busy falling. It stays high with result held.
- start in DONE clears done on the next edge and begins a new run.
- start while busy=1 is ignored.
- mm_done is ignored outside WAIT, including any stale level left over from the previous operation.
- resetn=0 mid-operation: all outputs return to their reset values on that edge. The partial result is discarded and the multiplier is held in reset.

## Structure
- Shared package mm_pkg:
  - State encoding for the six top states.
  - Sub-phase encoding (ARM/ISSUE/WAIT).
  - Default N.
- No sub-module inside this block. It is instantiated alongside the montgomery multiplier at the top level.
- The bench substitutes a behavioural Montgomery model with a configurable latency.

## Test plan
- N=8, E_WIDTH=4, M=13, R=9, R2=3, x=2, e=4'b0101 → result=6; exactly 8 mm_start pulses; done=1, busy=0.
- Same setup, e=0 → result=1; 6 operations.
- Same setup, e=4'b1111 → result=8 (2^15 mod 13); 10 operations; result and done held for 20 cycles.
- Model latency 1 cycle vs 50 cycles, with mm_done left high between operations → identical result 6; each capture occurs only after a fresh ARM/ISSUE.
- start pulsed while busy, and inputs changed mid-run → ignored; result=6.
- resetn low during the third operation → next edge: done=0, busy=0, mm_resetn=0, result=0. A fresh start then yields 6.
